// File: rtl/random_seq.sv
// Sequencer for one random node: loads seeds into the node's seed RAM, dumps them back out,
// and runs N sweeps that visit every replica slot once per sweep on both node ports.
module random_seq #(
   parameter int BASE_NUM = 32,
   parameter int BASE_LOG = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [CNT_W-1:0]    cmd_count,
   input  logic                cmd_or_en,
   input  logic                cmd_tw_en,
   input  logic                abort,
   input  logic                s_seed_valid,
   output logic                s_seed_ready,
   input  logic [63:0]         s_seed_data,
   output logic                m_seed_valid,
   input  logic                m_seed_ready,
   output logic [63:0]         m_seed_data,
   output logic [BASE_LOG-1:0] or_base_id,
   output logic [BASE_LOG-1:0] tw_base_id,
   output logic                run,
   output logic                init,
   output logic                read,
   output logic [63:0]         w_seed,
   output logic                or_opt_en,
   output logic                tw_opt_en,
   input  logic [63:0]         r_seed,
   input  logic                rnd_ready,
   output logic                busy,
   output logic                done
);

   // state    | meaning
   // S_IDLE   | waiting for a command, cmd_ready high
   // S_LOAD   | accepting seed beats, one node write per handshake
   // S_D_ADDR | dump: present slot address to the node
   // S_D_READ | dump: strobe read so the node captures r_seed
   // S_D_OUT  | dump: offer r_seed on the output stream until taken
   // S_R_WAIT | run: wait for the node to report ready between sweeps
   // S_R_RUN  | run: one sweep of BASE_NUM back-to-back run cycles
   // S_DONE   | one-cycle completion pulse
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_D_ADDR, S_D_READ, S_D_OUT, S_R_WAIT, S_R_RUN, S_DONE
   } state_t;

   localparam logic [BASE_LOG-1:0] ID_LAST = BASE_LOG'(BASE_NUM - 1);
   localparam logic [BASE_LOG-1:0] ID_HALF = BASE_LOG'(BASE_NUM / 2);
   localparam logic [BASE_LOG-1:0] ID_ONE  = BASE_LOG'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

   state_t              state, state_nxt;
   logic [BASE_LOG-1:0] id;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    count_q;
   logic                or_en_q;
   logic                tw_en_q;

   logic accept;
   logic last_id;
   logic do_abort;

   assign accept   = cmd_valid && (state == S_IDLE);
   assign last_id  = (id == ID_LAST);
   assign do_abort = abort && (state != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  2'd0:    state_nxt = S_LOAD;
                  2'd1:    state_nxt = S_D_ADDR;
                  2'd2:    state_nxt = (cmd_count == '0) ? S_DONE : S_R_WAIT;
                  default: state_nxt = S_DONE;
               endcase
            end
         end
         S_LOAD:   if (s_seed_valid && last_id) state_nxt = S_DONE;
         S_D_ADDR: state_nxt = S_D_READ;
         S_D_READ: state_nxt = S_D_OUT;
         S_D_OUT:  if (m_seed_ready) state_nxt = last_id ? S_DONE : S_D_ADDR;
         // cnt already equals count after the final sweep, so this wait doubles as the drain
         S_R_WAIT: if (rnd_ready) state_nxt = (cnt == count_q) ? S_DONE : S_R_RUN;
         S_R_RUN:  if (last_id) state_nxt = S_R_WAIT;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (do_abort) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id      <= '0;
         cnt     <= '0;
         count_q <= '0;
         or_en_q <= 1'b0;
         tw_en_q <= 1'b0;
      end else if (accept) begin
         id      <= '0;
         cnt     <= '0;
         count_q <= cmd_count;
         or_en_q <= cmd_or_en;
         tw_en_q <= cmd_tw_en;
      end else if (do_abort) begin
         id <= '0;
      end else begin
         case (state)
            S_LOAD:  if (s_seed_valid) id <= id + ID_ONE;
            S_D_OUT: if (m_seed_ready) id <= id + ID_ONE;
            S_R_RUN: begin
               id <= id + ID_ONE;
               if (last_id) cnt <= cnt + CNT_ONE;
            end
            default: id <= id;
         endcase
      end
   end

   always_comb begin
      cmd_ready    = 1'b0;
      s_seed_ready = 1'b0;
      m_seed_valid = 1'b0;
      m_seed_data  = '0;
      or_base_id   = '0;
      tw_base_id   = '0;
      run          = 1'b0;
      init         = 1'b0;
      read         = 1'b0;
      w_seed       = '0;
      or_opt_en    = 1'b0;
      tw_opt_en    = 1'b0;
      done         = 1'b0;
      busy         = (state != S_IDLE);
      case (state)
         S_IDLE: cmd_ready = 1'b1;
         S_LOAD: begin
            s_seed_ready = 1'b1;
            if (s_seed_valid) begin
               init       = 1'b1;
               w_seed     = s_seed_data;
               or_base_id = id;
            end
         end
         S_D_ADDR: or_base_id = id;
         S_D_READ: begin
            or_base_id = id;
            read       = 1'b1;
         end
         S_D_OUT: begin
            m_seed_valid = 1'b1;
            m_seed_data  = r_seed;
         end
         S_R_RUN: begin
            run        = 1'b1;
            or_base_id = id;
            tw_base_id = id + ID_HALF;
            or_opt_en  = or_en_q;
            tw_opt_en  = tw_en_q;
         end
         S_DONE:  done = 1'b1;
         default: busy = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_random_seq.sv
// Bench for random_seq: a behavioural seed node plus queue scoreboards for the init,
// dump and run streams, driven by directed and randomized commands.
module tb_random_seq;
   localparam int BN = 32;
   localparam int BL = 5;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [CW-1:0] cmd_count = '0;
   logic          cmd_or_en = 1'b0;
   logic          cmd_tw_en = 1'b0;
   logic          abort = 1'b0;
   logic          s_seed_valid = 1'b0;
   logic          s_seed_ready;
   logic [63:0]   s_seed_data = '0;
   logic          m_seed_valid;
   logic          m_seed_ready = 1'b0;
   logic [63:0]   m_seed_data;
   logic [BL-1:0] or_base_id, tw_base_id;
   logic          run, init, read;
   logic [63:0]   w_seed;
   logic          or_opt_en, tw_opt_en;
   logic [63:0]   r_seed = '0;
   logic          rnd_ready = 1'b1;
   logic          busy, done;

   random_seq #(.BASE_NUM(BN), .BASE_LOG(BL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
      .cmd_or_en(cmd_or_en), .cmd_tw_en(cmd_tw_en), .abort(abort),
      .s_seed_valid(s_seed_valid), .s_seed_ready(s_seed_ready), .s_seed_data(s_seed_data),
      .m_seed_valid(m_seed_valid), .m_seed_ready(m_seed_ready), .m_seed_data(m_seed_data),
      .or_base_id(or_base_id), .tw_base_id(tw_base_id), .run(run), .init(init), .read(read),
      .w_seed(w_seed), .or_opt_en(or_opt_en), .tw_opt_en(tw_opt_en), .r_seed(r_seed),
      .rnd_ready(rnd_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // behavioural random node: seed RAM written on init, read into r_seed on read
   logic [63:0] node_ram [BN];
   always @(posedge clk) begin
      if (init) node_ram[or_base_id] <= w_seed;
      if (read) r_seed <= node_ram[or_base_id];
   end

   typedef struct { int id; logic [63:0] d; } beat_t;
   typedef struct { int or_id; int tw_id; bit or_en; bit tw_en; } run_t;

   beat_t       q_init[$];
   logic [63:0] q_dump[$];
   run_t        q_run[$];
   logic [63:0] model_mem [BN];
   logic [63:0] seeds [BN];

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // monitor: pops expectations whenever the DUT presents a beat
   beat_t       mb;
   run_t        mr;
   logic [63:0] stall_data = '0;
   bit          stall_prev = 0, run_prev = 0, rr_prev = 1, abort_burst = 0;
   int          streak = 0;

   always @(negedge clk) begin
      if (!reset) begin
         stall_prev = 0;
         run_prev   = 0;
         streak     = 0;
      end else begin
         if (init) begin
            if (q_init.size() == 0) chk("init_unexpected", init, 0);
            else begin
               mb = q_init.pop_front();
               chk("init_id", or_base_id, mb.id);
               chk("init_data", w_seed, mb.d);
            end
         end
         if (m_seed_valid) begin
            if (stall_prev) chk("dump_stable", m_seed_data, stall_data);
            if (m_seed_ready) begin
               if (q_dump.size() == 0) chk("dump_unexpected", m_seed_valid, 0);
               else chk("dump_data", m_seed_data, q_dump.pop_front());
               stall_prev = 0;
            end else begin
               stall_prev = 1;
               stall_data = m_seed_data;
            end
         end else stall_prev = 0;
         if (run) begin
            if (!run_prev) chk("run_start_rnd_ready", rr_prev, 1);
            if (q_run.size() == 0) chk("run_unexpected", run, 0);
            else begin
               mr = q_run.pop_front();
               chk("run_or_id", or_base_id, mr.or_id);
               chk("run_tw_id", tw_base_id, mr.tw_id);
               chk("run_opt_en", {or_opt_en, tw_opt_en}, {mr.or_en, mr.tw_en});
            end
            streak++;
         end else if (run_prev) begin
            if (abort_burst) abort_burst = 0;
            else chk("burst_len", streak, BN);
            streak = 0;
         end
         run_prev = run;
         if (done) done_cnt++;
      end
      rr_prev = rnd_ready;
   end

   task automatic issue(input logic [1:0] op, input int cnt, input bit oe, input bit te);
      @(posedge clk); #1;
      cmd_op = op; cmd_count = CW'(cnt); cmd_or_en = oe; cmd_tw_en = te; cmd_valid = 1'b1;
      @(negedge clk);
      chk("cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic push_load(input bit keep);
      for (int i = 0; i < BN; i++) begin
         q_init.push_back('{id: i, d: seeds[i]});
         if (keep) model_mem[i] = seeds[i];
      end
   endtask

   task automatic push_run(input int cnt, input bit oe, input bit te);
      for (int s = 0; s < cnt; s++)
         for (int k = 0; k < BN; k++)
            q_run.push_back('{or_id: k, tw_id: (k + BN/2) % BN, or_en: oe, tw_en: te});
   endtask

   task automatic load_beats(input int nb, input bit gaps);
      int  i = 0;
      int  guard = 0;
      bit  hs;
      while (i < nb && guard < 1000) begin
         #1;
         if (gaps && ($urandom % 3 == 0)) s_seed_valid = 1'b0;
         else begin
            s_seed_valid = 1'b1;
            s_seed_data  = seeds[i];
         end
         @(negedge clk);
         hs = s_seed_valid && s_seed_ready;
         @(posedge clk);
         if (hs) i++;
         guard++;
      end
      #1 s_seed_valid = 1'b0;
      chk("load_beats", i, nb);
   endtask

   task automatic wait_done(input string nm, input int bound, input bit tog, output int n);
      bit seen = 0;
      n = 0;
      while (n < bound) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         n++;
         @(posedge clk); #1;
         if (tog) m_seed_ready = 1'($urandom % 2);
      end
      chk(nm, seen, 1);
   endtask

   initial begin
      int  n, d0, bursts, low_left, c;
      bit  seen, prev_rr, found, oe, te;

      #2;
      chk("por_strobes", {init, read, run, s_seed_ready, m_seed_valid, done, busy,
                          or_opt_en, tw_opt_en, or_base_id, tw_base_id}, 0);
      chk("por_cmd_ready", cmd_ready, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // test 1: reset mid-load after 7 beats
      for (int i = 0; i < BN; i++) seeds[i] = 64'h2000 + 64'(i);
      issue(2'd0, 0, 0, 0);
      push_load(0);
      load_beats(7, 0);
      #1 chk("t1_id_before_reset", dut.busy, 1);
      reset = 1'b0;
      #1;
      chk("t1_rst_strobes", {init, read, run, s_seed_ready, m_seed_valid, done, busy,
                             or_opt_en, tw_opt_en, or_base_id, tw_base_id}, 0);
      chk("t1_rst_w_seed", w_seed, 0);
      chk("t1_init_count", q_init.size(), BN - 7);
      q_init.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t1_cmd_ready", cmd_ready, 1);

      // test 2: full load with random valid gaps
      for (int i = 0; i < BN; i++) seeds[i] = 64'h1000 + 64'(i);
      issue(2'd0, 0, 0, 0);
      push_load(1);
      load_beats(BN, 1);
      wait_done("t2_done", 50, 0, n);
      chk("t2_done_latency", n, 0);
      chk("t2_init_left", q_init.size(), 0);

      // test 3: dump with random output stalls
      issue(2'd1, 0, 0, 0);
      for (int i = 0; i < BN; i++) q_dump.push_back(model_mem[i]);
      d0 = done_cnt;
      wait_done("t3_done", 2000, 1, n);
      @(posedge clk); #1 m_seed_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t3_dump_left", q_dump.size(), 0);
      chk("t3_done_once", done_cnt - d0, 1);

      // test 4: three sweeps with rnd_ready gaps before sweep 2 and before done
      issue(2'd2, 3, 1, 0);
      push_run(3, 1, 0);
      bursts = 0; low_left = 0; n = 0; seen = 0; prev_rr = 1;
      while (!seen && n < 3000) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            chk("t4_done_after_drain", prev_rr, 1);
         end else begin
            if (run && or_base_id == BL'(BN - 1)) begin
               bursts++;
               if (bursts == 1) low_left = 5;
               else if (bursts == 3) low_left = 4;
            end
            prev_rr = rnd_ready;
            @(posedge clk); #1;
            if (low_left > 0) begin
               rnd_ready = 1'b0;
               low_left--;
            end else rnd_ready = 1'b1;
            n++;
         end
      end
      chk("t4_done_seen", seen, 1);
      chk("t4_bursts", bursts, 3);
      chk("t4_run_left", q_run.size(), 0);

      // randomized run
      c  = $urandom_range(1, 2);
      oe = 1'($urandom % 2);
      te = 1'($urandom % 2);
      issue(2'd2, c, oe, te);
      push_run(c, oe, te);
      wait_done("t4r_done", 2000, 0, n);
      chk("t4r_run_left", q_run.size(), 0);

      // test 5: zero-count run and reserved op
      issue(2'd2, 0, 1, 1);
      wait_done("t5_run0_done", 10, 0, n);
      chk("t5_run0_latency_ok", (n <= 1), 1);
      issue(2'd3, 5, 1, 1);
      wait_done("t5_nop_done", 10, 0, n);
      chk("t5_nop_latency_ok", (n <= 1), 1);

      // test 6: abort during k=10 of the first sweep
      oe = 1'($urandom % 2);
      te = 1'($urandom % 2);
      abort_burst = 1;
      issue(2'd2, 2, oe, te);
      push_run(2, oe, te);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (run && or_base_id == BL'(9)) begin
            found = 1;
            break;
         end
      end
      chk("t6_found_k9", found, 1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("t6_run_low", run, 0);
      chk("t6_busy", busy, 0);
      chk("t6_runs_before_abort", q_run.size(), 2*BN - 11);
      q_run.delete();
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1 chk("t6_no_done", done_cnt, d0);

      for (int i = 0; i < BN; i++) seeds[i] = {$urandom, $urandom};
      issue(2'd0, 0, 0, 0);
      push_load(1);
      load_beats(BN, 1);
      wait_done("t6_load_done", 50, 0, n);
      issue(2'd1, 0, 0, 0);
      for (int i = 0; i < BN; i++) q_dump.push_back(model_mem[i]);
      wait_done("t6_dump_done", 2000, 1, n);
      @(posedge clk); #1 m_seed_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("t6_dump_left", q_dump.size(), 0);
      chk("t6_init_left", q_init.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
      $fatal(1, "timeout");
   end
endmodule
